pong_score_display: RTL and testbench

Score-display sequencer for the Pong scoreboard. Drives the 4-bit codes of four seven-segment digit decoders: a "PonG" splash after reset, then live two-digit BCD scores for both players, then a blinking winner display at game end. Sits between the game-logic point pulses and the four decoder instances (digit 3 leftmost).

---
 rtl/pong_score_display_if.sv | 27 ++
 rtl/pong_score_display.sv | 183 ++++++++++++++++++
 tb/tb_pong_score_display.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pong_score_display_if.sv
// Signal bundle between the Pong game logic and the scoreboard sequencer.
// Handshake semantics: there is no valid/ready pair. game_start, point_p1 and
// point_p2 are single-cycle strobes sampled on every rising clock edge. The
// outputs are registered levels that are valid in every cycle.
interface pong_score_display_if;
    logic       game_start;
    logic       point_p1;
    logic       point_p2;
    logic [3:0] hex3;
    logic [3:0] hex2;
    logic [3:0] hex1;
    logic [3:0] hex0;
    logic       game_over;
    logic [1:0] winner;

    // Game logic / stimulus side: drives the strobes and observes the display.
    modport master (
        output game_start, point_p1, point_p2,
        input  hex3, hex2, hex1, hex0, game_over, winner
    );

    // Sequencer side: consumes the strobes and drives the display.
    modport slave (
        input  game_start, point_p1, point_p2,
        output hex3, hex2, hex1, hex0, game_over, winner
    );
endinterface

// File: rtl/pong_score_display.sv
// Scoreboard sequencer: "PonG" splash after reset, live two-digit BCD scores
// during play, and a blinking winner display once a player reaches WIN_SCORE.
// All outputs are registered from the next-state values, so a change decided
// in cycle N is visible in cycle N+1.
module pong_score_display #(
    parameter int SPLASH_CYCLES = 50_000_000,
    parameter int BLINK_CYCLES  = 12_500_000,
    parameter int WIN_SCORE     = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    pong_score_display_if.slave  bus,
    output logic [1:0]           dbgState
);
    localparam int SW = $clog2(SPLASH_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [SW-1:0] SPLASH_LAST = SW'(SPLASH_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);
    localparam logic [6:0]    WIN_BIN     = 7'(WIN_SCORE);

    localparam logic [3:0] CODE_P     = 4'hA;
    localparam logic [3:0] CODE_O     = 4'hB;
    localparam logic [3:0] CODE_N     = 4'hC;
    localparam logic [3:0] CODE_G     = 4'hD;
    localparam logic [3:0] CODE_BLANK = 4'hE;

    typedef enum logic [1:0] {
        SPLASH = 2'd0,
        PLAY   = 2'd1,
        WIN    = 2'd2
    } state_t;

    state_t        state, nextState;
    logic [SW-1:0] splashCnt, nextSplashCnt;
    logic [BW-1:0] blinkCnt, nextBlinkCnt;
    logic          visible, nextVisible;
    logic [1:0]    winnerReg, nextWinner;
    logic [3:0]    p1Tens, p1Ones, p2Tens, p2Ones;
    logic [3:0]    nextP1Tens, nextP1Ones, nextP2Tens, nextP2Ones;
    logic [6:0]    p1Bin, p2Bin, nextP1Bin, nextP2Bin;
    logic          p1Win, p2Win;
    logic [3:0]    dHex3, dHex2, dHex1, dHex0;
    logic          p1Hidden, p2Hidden;

    assign dbgState = state;
    assign p1Win    = (p1Bin == WIN_BIN);
    assign p2Win    = (p2Bin == WIN_BIN);

    // BCD increment of a two-digit score: ones wraps 9->0 and carries into tens.
    function automatic logic [7:0] bcdInc(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

    // Tens digit of zero is suppressed to blank.
    function automatic logic [3:0] tensCode(input logic [3:0] tens);
        return (tens == 4'd0) ? CODE_BLANK : tens;
    endfunction

    // Next-state, score, blink and winner decisions.
    always_comb begin
        nextState     = state;
        nextSplashCnt = splashCnt;
        nextBlinkCnt  = blinkCnt;
        nextVisible   = visible;
        nextWinner    = winnerReg;
        nextP1Tens    = p1Tens;
        nextP1Ones    = p1Ones;
        nextP1Bin     = p1Bin;
        nextP2Tens    = p2Tens;
        nextP2Ones    = p2Ones;
        nextP2Bin     = p2Bin;
        case (state)
            SPLASH: begin
                if (bus.game_start || splashCnt == SPLASH_LAST) begin
                    nextState     = PLAY;
                    nextSplashCnt = '0;
                    nextP1Tens = '0; nextP1Ones = '0; nextP1Bin = '0;
                    nextP2Tens = '0; nextP2Ones = '0; nextP2Bin = '0;
                end else begin
                    nextSplashCnt = splashCnt + 1'b1;
                end
            end
            PLAY: begin
                if (bus.game_start) begin
                    // Restart wins over any point strobe in the same cycle.
                    nextP1Tens = '0; nextP1Ones = '0; nextP1Bin = '0;
                    nextP2Tens = '0; nextP2Ones = '0; nextP2Bin = '0;
                end else if (p1Win || p2Win) begin
                    // Scores are frozen once someone has reached the target.
                    nextState    = WIN;
                    nextWinner   = {p1Win, p2Win};
                    nextBlinkCnt = '0;
                    nextVisible  = 1'b1;
                end else begin
                    if (bus.point_p1) begin
                        {nextP1Tens, nextP1Ones} = bcdInc(p1Tens, p1Ones);
                        nextP1Bin = p1Bin + 7'd1;
                    end
                    if (bus.point_p2) begin
                        {nextP2Tens, nextP2Ones} = bcdInc(p2Tens, p2Ones);
                        nextP2Bin = p2Bin + 7'd1;
                    end
                end
            end
            WIN: begin
                if (bus.game_start) begin
                    nextState  = PLAY;
                    nextWinner = 2'b00;
                    nextP1Tens = '0; nextP1Ones = '0; nextP1Bin = '0;
                    nextP2Tens = '0; nextP2Ones = '0; nextP2Bin = '0;
                end else if (blinkCnt == BLINK_LAST) begin
                    nextBlinkCnt = '0;
                    nextVisible  = ~visible;
                end else begin
                    nextBlinkCnt = blinkCnt + 1'b1;
                end
            end
            default: begin
                nextState = SPLASH;
            end
        endcase
    end

    // Digit codes derived from the next-state values so they register in step.
    always_comb begin
        p1Hidden = (nextState == WIN) && nextWinner[1] && !nextVisible;
        p2Hidden = (nextState == WIN) && nextWinner[0] && !nextVisible;
        dHex3 = CODE_P;
        dHex2 = CODE_O;
        dHex1 = CODE_N;
        dHex0 = CODE_G;
        if (nextState != SPLASH) begin
            dHex3 = p1Hidden ? CODE_BLANK : tensCode(nextP1Tens);
            dHex2 = p1Hidden ? CODE_BLANK : nextP1Ones;
            dHex1 = p2Hidden ? CODE_BLANK : tensCode(nextP2Tens);
            dHex0 = p2Hidden ? CODE_BLANK : nextP2Ones;
        end
    end

    // State, counters, scores and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= SPLASH;
            splashCnt     <= '0;
            blinkCnt      <= '0;
            visible       <= 1'b1;
            winnerReg     <= 2'b00;
            p1Tens        <= '0;
            p1Ones        <= '0;
            p1Bin         <= '0;
            p2Tens        <= '0;
            p2Ones        <= '0;
            p2Bin         <= '0;
            bus.hex3      <= CODE_P;
            bus.hex2      <= CODE_O;
            bus.hex1      <= CODE_N;
            bus.hex0      <= CODE_G;
            bus.game_over <= 1'b0;
            bus.winner    <= 2'b00;
        end else begin
            state         <= nextState;
            splashCnt     <= nextSplashCnt;
            blinkCnt      <= nextBlinkCnt;
            visible       <= nextVisible;
            winnerReg     <= nextWinner;
            p1Tens        <= nextP1Tens;
            p1Ones        <= nextP1Ones;
            p1Bin         <= nextP1Bin;
            p2Tens        <= nextP2Tens;
            p2Ones        <= nextP2Ones;
            p2Bin         <= nextP2Bin;
            bus.hex3      <= dHex3;
            bus.hex2      <= dHex2;
            bus.hex1      <= dHex1;
            bus.hex0      <= dHex0;
            bus.game_over <= (nextState == WIN);
            bus.winner    <= nextWinner;
        end
    end
endmodule

// File: tb/tb_pong_score_display.sv
// Directed bench for the Pong score display sequencer (splash 8, blink 4, win 11).
module tb_pong_score_display;
    logic       clock;
    logic       reset;
    logic [1:0] dbgState;
    int         total;
    int         bad;

    pong_score_display_if bus ();

    pong_score_display #(
        .SPLASH_CYCLES(8),
        .BLINK_CYCLES (4),
        .WIN_SCORE    (11)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .dbgState(dbgState)
    );

    // Clock and reset block.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] hexAll();
        return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
    endfunction

    // Single comparison point.
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive a one-cycle strobe pattern, then release it.
    task automatic pulse(input logic gs, input logic p1, input logic p2);
        bus.game_start = gs;
        bus.point_p1   = p1;
        bus.point_p2   = p2;
        step();
        bus.game_start = 1'b0;
        bus.point_p1   = 1'b0;
        bus.point_p2   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.game_start = 1'b0;
        bus.point_p1   = 1'b0;
        bus.point_p2   = 1'b0;
        steps(2);
        chk("reset_hex", hexAll(), 16'hABCD);
        chk("reset_over", {15'd0, bus.game_over}, 16'd0);
        chk("reset_winner", {14'd0, bus.winner}, 16'd0);

        // Splash for exactly 8 cycles, then the zero score display.
        reset = 1'b0;
        chk("splash_c0", hexAll(), 16'hABCD);
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("splash_c%0d", i), hexAll(), 16'hABCD);
        end
        step();
        chk("play_first", hexAll(), 16'hE0E0);
        chk("play_over", {15'd0, bus.game_over}, 16'd0);
        chk("play_winner", {14'd0, bus.winner}, 16'd0);

        // Early start during splash; points during splash are ignored.
        reset = 1'b1;
        #1;
        chk("rst_async_a", hexAll(), 16'hABCD);
        reset = 1'b0;
        pulse(1'b0, 1'b1, 1'b1);
        chk("splash_pts", hexAll(), 16'hABCD);
        steps(2);
        pulse(1'b1, 1'b0, 1'b0);
        chk("early_start", hexAll(), 16'hE0E0);

        // Ten points for P1: 9 -> 10 carry, tens digit appears.
        for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1, 1'b0);
        chk("p1_nine", hexAll(), 16'hE9E0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("p1_ten", hexAll(), 16'h10E0);

        // P2 to ten, then a simultaneous point: draw.
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0, 1'b1);
        chk("p2_ten", hexAll(), 16'h1010);
        pulse(1'b0, 1'b1, 1'b1);
        chk("draw_score", hexAll(), 16'h1111);
        chk("draw_over_n1", {15'd0, bus.game_over}, 16'd0);
        step();
        chk("draw_over", {15'd0, bus.game_over}, 16'd1);
        chk("draw_winner", {14'd0, bus.winner}, 16'h3);
        chk("draw_vis0", hexAll(), 16'h1111);
        steps(3);
        chk("draw_vis3", hexAll(), 16'h1111);
        step();
        chk("draw_hid0", hexAll(), 16'hEEEE);
        steps(3);
        chk("draw_hid3", hexAll(), 16'hEEEE);
        step();
        chk("draw_vis_again", hexAll(), 16'h1111);

        // Restart from WIN with a simultaneous point: point discarded.
        pulse(1'b1, 1'b0, 1'b1);
        chk("restart_hex", hexAll(), 16'hE0E0);
        chk("restart_over", {15'd0, bus.game_over}, 16'd0);
        chk("restart_winner", {14'd0, bus.winner}, 16'd0);

        // P1 wins 11 to 3.
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1);
        chk("p2_three", hexAll(), 16'hE0E3);
        for (int i = 0; i < 11; i++) pulse(1'b0, 1'b1, 1'b0);
        chk("p1_eleven", hexAll(), 16'h11E3);
        step();
        chk("p1_over", {15'd0, bus.game_over}, 16'd1);
        chk("p1_winner", {14'd0, bus.winner}, 16'h2);
        chk("p1_vis0", hexAll(), 16'h11E3);
        pulse(1'b0, 1'b1, 1'b1);
        chk("p1_vis1_frozen", hexAll(), 16'h11E3);
        steps(2);
        chk("p1_vis3", hexAll(), 16'h11E3);
        step();
        chk("p1_hid0", hexAll(), 16'hEEE3);
        pulse(1'b0, 1'b1, 1'b1);
        chk("p1_hid1_frozen", hexAll(), 16'hEEE3);
        steps(2);
        chk("p1_hid3", hexAll(), 16'hEEE3);
        step();
        chk("p1_vis_again", hexAll(), 16'h11E3);
        chk("p1_winner_hold", {14'd0, bus.winner}, 16'h2);

        // Reset in the middle of play.
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("mid_play", hexAll(), 16'hE1E0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_hex", hexAll(), 16'hABCD);
        chk("mid_reset_over", {15'd0, bus.game_over}, 16'd0);
        steps(2);
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
